// File: rtl/ddr3_app_arbiter_if.sv
// Command-port bundle shared by the write controller, the readout controller,
// the MIG user interface and the arbiter that sits between them.
interface ddr3_app_arbiter_if;
   logic        wr_app_en;
   logic [25:0] wr_app_addr;
   logic        wr_app_rdy;
   logic        rd_app_en;
   logic [25:0] rd_app_addr;
   logic        rd_app_rdy;
   logic        app_en;
   logic [2:0]  app_cmd;
   logic [25:0] app_addr;
   logic        app_rdy;
   logic        wr_grant;
   logic        rd_grant;

   // Arbiter view: takes requests and MIG ready, drives the MIG command and grants
   modport master (
      input  wr_app_en, wr_app_addr, rd_app_en, rd_app_addr, app_rdy,
      output wr_app_rdy, rd_app_rdy, app_en, app_cmd, app_addr, wr_grant, rd_grant
   );

   // Environment view: requesters and MIG
   modport slave (
      output wr_app_en, wr_app_addr, rd_app_en, rd_app_addr, app_rdy,
      input  wr_app_rdy, rd_app_rdy, app_en, app_cmd, app_addr, wr_grant, rd_grant
   );
endinterface

// File: rtl/ddr3_app_arbiter.sv
// Shares the single MIG command port between the write controller and the
// readout controller: bounded bursts, round-robin on ties, fixed idle gap
// between owners. Commands pass through combinationally while granted.
//
// state  | meaning
// S_IDLE | no owner; waits for calibration and a request
// S_WR   | write controller owns the port
// S_RD   | readout controller owns the port
// S_TURN | port forced idle for TURNAROUND cycles before the owner changes
module ddr3_app_arbiter #(
   parameter int MAX_BURST  = 16,
   parameter int TURNAROUND = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                init_calib_complete_i,
   ddr3_app_arbiter_if.master  bus
);

   localparam int              CW        = $clog2(MAX_BURST + 1);
   localparam int              TW        = $clog2(TURNAROUND + 1);
   localparam logic [CW-1:0]   CNT_MAX   = CW'(MAX_BURST);
   localparam logic [CW-1:0]   CNT_LAST  = CW'(MAX_BURST - 1);
   localparam logic [TW-1:0]   TURN_LOAD = TW'(TURNAROUND - 1);

   typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_TURN} state_t;

   state_t          state_q;
   logic            last_rd_q;
   logic [CW-1:0]   grant_cnt_q;
   logic [CW-1:0]   grant_cnt_d;
   logic [TW-1:0]   turn_cnt_q;
   logic            wr_grant_q;
   logic            rd_grant_q;

   logic            own_wr;
   logic            own_rd;
   logic            app_en_w;
   logic            accept;
   logic            safe;
   logic            burst_full;
   logic            own_req;
   logic            other_req;
   logic            yield;

   assign own_wr = (state_q == S_WR);
   assign own_rd = (state_q == S_RD);

   // Calibration gates the command strobe and both readies, so a requester
   // never sees an acceptance for a command the MIG did not receive.
   assign app_en_w       = init_calib_complete_i &
                           ((own_wr & bus.wr_app_en) | (own_rd & bus.rd_app_en));
   assign bus.app_en     = app_en_w;
   assign bus.app_cmd    = own_rd ? 3'b001 : 3'b000;
   assign bus.app_addr   = own_wr ? bus.wr_app_addr : (own_rd ? bus.rd_app_addr : '0);
   assign bus.wr_app_rdy = own_wr & init_calib_complete_i & bus.app_rdy;
   assign bus.rd_app_rdy = own_rd & init_calib_complete_i & bus.app_rdy;
   assign bus.wr_grant   = wr_grant_q;
   assign bus.rd_grant   = rd_grant_q;

   // A presented command may only be dropped once the MIG has taken it.
   assign accept     = app_en_w & bus.app_rdy;
   assign safe       = ~app_en_w | bus.app_rdy;
   // Counting this cycle's acceptance lets the burst end on exactly MAX_BURST.
   assign burst_full = (grant_cnt_q == CNT_MAX) | (accept & (grant_cnt_q == CNT_LAST));
   assign own_req    = own_wr ? bus.wr_app_en : bus.rd_app_en;
   assign other_req  = own_wr ? bus.rd_app_en : bus.wr_app_en;
   assign yield      = other_req & (~own_req | burst_full) & safe;

   // Saturating count of commands accepted under the current grant
   always_comb begin
      grant_cnt_d = grant_cnt_q;
      if (accept && (grant_cnt_q != CNT_MAX)) grant_cnt_d = grant_cnt_q + CW'(1);
   end

   // Ownership FSM with registered grant flags
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         last_rd_q   <= 1'b1;
         grant_cnt_q <= '0;
         turn_cnt_q  <= '0;
         wr_grant_q  <= 1'b0;
         rd_grant_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (init_calib_complete_i) begin
                  if (bus.wr_app_en && (!bus.rd_app_en || last_rd_q)) begin
                     state_q     <= S_WR;
                     last_rd_q   <= 1'b0;
                     grant_cnt_q <= '0;
                     wr_grant_q  <= 1'b1;
                  end else if (bus.rd_app_en) begin
                     state_q     <= S_RD;
                     last_rd_q   <= 1'b1;
                     grant_cnt_q <= '0;
                     rd_grant_q  <= 1'b1;
                  end
               end
            end
            S_WR, S_RD: begin
               grant_cnt_q <= grant_cnt_d;
               // app_en is already forced low without calibration, so this is a safe cycle
               if (!init_calib_complete_i) begin
                  state_q    <= S_IDLE;
                  wr_grant_q <= 1'b0;
                  rd_grant_q <= 1'b0;
               end else if (yield) begin
                  state_q    <= S_TURN;
                  turn_cnt_q <= TURN_LOAD;
                  wr_grant_q <= 1'b0;
                  rd_grant_q <= 1'b0;
               end
            end
            S_TURN: begin
               if (turn_cnt_q == '0) begin
                  grant_cnt_q <= '0;
                  if (last_rd_q) begin
                     state_q    <= S_WR;
                     last_rd_q  <= 1'b0;
                     wr_grant_q <= 1'b1;
                  end else begin
                     state_q    <= S_RD;
                     last_rd_q  <= 1'b1;
                     rd_grant_q <= 1'b1;
                  end
               end else begin
                  turn_cnt_q <= turn_cnt_q - TW'(1);
               end
            end
            default: begin
               state_q    <= S_IDLE;
               wr_grant_q <= 1'b0;
               rd_grant_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Bench for ddr3_app_arbiter: a per-cycle vector table for grant/gating
// behaviour, a command scoreboard for burst alternation, and short sequences
// for stall-then-yield and asynchronous reset.
module tb_ddr3_app_arbiter;

   localparam int MAX_BURST  = 16;
   localparam int TURNAROUND = 2;

   logic clk_i = 1'b0;
   logic rst_i;
   logic calib;

   ddr3_app_arbiter_if bus();

   ddr3_app_arbiter #(.MAX_BURST(MAX_BURST), .TURNAROUND(TURNAROUND)) dut (
      .clk_i                 (clk_i),
      .rst_i                 (rst_i),
      .init_calib_complete_i (calib),
      .bus                   (bus)
   );

   always #5 clk_i = ~clk_i;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic       c, w, r, y;
      logic       en;
      logic [2:0] cmd;
      int         src;
      logic       wg, rg, wy, ry;
   } vec_t;

   typedef struct {
      logic [2:0]  cmd;
      logic [25:0] addr;
      int          gap;
   } exp_t;

   exp_t sbq[$];

   function automatic vec_t mk(input logic c, w, r, y, en, input logic [2:0] cmd,
                               input int src, input logic wg, rg, wy, ry);
      vec_t v;
      v.c = c; v.w = w; v.r = r; v.y = y; v.en = en; v.cmd = cmd; v.src = src;
      v.wg = wg; v.rg = rg; v.wy = wy; v.ry = ry;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic c, w, r, y);
      calib         = c;
      bus.wr_app_en = w;
      bus.rd_app_en = r;
      bus.app_rdy   = y;
   endtask

   task automatic next_cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      set_in(0, 0, 0, 0);
      next_cyc();
      rst_i = 1'b0;
   endtask

   // Owner holds its request through a long burst, then the other side
   // arrives while the MIG stalls: the presented command must be held until
   // accepted, then TURNAROUND idle cycles, then the other owner.
   task automatic stall_yield(input bit own_wr, input int ncmd);
      logic [25:0] oa;
      logic [25:0] xa;
      int acc;
      int bad;
      oa  = own_wr ? 26'h0333000 : 26'h0444000;
      xa  = 26'h3000001;
      acc = 0;
      bad = 0;
      do_reset();
      set_in(1, own_wr, !own_wr, 1);
      for (int c = 0; c <= ncmd; c++) begin
         bus.wr_app_addr = own_wr ? oa + 26'(acc) : xa;
         bus.rd_app_addr = own_wr ? xa : oa + 26'(acc);
         #3;
         if (c > 0 && (own_wr ? bus.wr_grant : bus.rd_grant) !== 1'b1) bad++;
         if (bus.app_en && bus.app_rdy) acc++;
         next_cyc();
      end
      check(own_wr ? "wr_solo_accepted" : "rd_solo_accepted", acc, ncmd);
      check(own_wr ? "wr_solo_grant_lost" : "rd_solo_grant_lost", bad, 0);
      if (own_wr) bus.rd_app_en = 1'b1; else bus.wr_app_en = 1'b1;
      bus.app_rdy = 1'b0;
      for (int s = 0; s < 5; s++) begin
         bus.wr_app_addr = own_wr ? oa + 26'(acc) : xa;
         bus.rd_app_addr = own_wr ? xa : oa + 26'(acc);
         #3;
         check("stall_app_en", bus.app_en, 1);
         check("stall_addr", bus.app_addr, oa + 26'(acc));
         check("stall_own_grant", own_wr ? bus.wr_grant : bus.rd_grant, 1);
         next_cyc();
      end
      bus.app_rdy = 1'b1;
      #3;
      check("release_app_en", bus.app_en, 1);
      check("release_own_rdy", own_wr ? bus.wr_app_rdy : bus.rd_app_rdy, 1);
      next_cyc();
      acc++;
      bus.wr_app_addr = own_wr ? oa + 26'(acc) : xa;
      bus.rd_app_addr = own_wr ? xa : oa + 26'(acc);
      for (int t = 0; t < TURNAROUND; t++) begin
         #3;
         check("turn_app_en", bus.app_en, 0);
         check("turn_grants", {bus.wr_grant, bus.rd_grant}, 2'b00);
         check("turn_rdys", {bus.wr_app_rdy, bus.rd_app_rdy}, 2'b00);
         next_cyc();
      end
      #3;
      check("new_owner_grant", own_wr ? bus.rd_grant : bus.wr_grant, 1);
      check("new_owner_app_en", bus.app_en, 1);
      check("new_owner_cmd", bus.app_cmd, own_wr ? 3'b001 : 3'b000);
      check("new_owner_addr", bus.app_addr, xa);
      next_cyc();
      set_in(1, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        tbl[34];
      logic [25:0] wa, ra, ea;
      int          wk, rk, idle, cycles;
      logic        wacc, racc;
      exp_t        it;

      // Table: calibration gating, first grant latency, keeping an idle grant,
      // calibration loss, round-robin tie, yield on owner idle, turnaround.
      for (int i = 0; i < 20; i++) tbl[i] = mk(0,1,0,1, 0,3'b000,0, 0,0,0,0);
      tbl[20] = mk(1,1,0,0, 0,3'b000,0, 0,0,0,0);
      tbl[21] = mk(1,1,0,0, 1,3'b000,1, 1,0,0,0);
      tbl[22] = mk(1,1,0,1, 1,3'b000,1, 1,0,1,0);
      tbl[23] = mk(1,0,0,0, 0,3'b000,1, 1,0,0,0);
      tbl[24] = mk(0,1,0,1, 0,3'b000,1, 1,0,0,0);
      tbl[25] = mk(0,1,0,1, 0,3'b000,0, 0,0,0,0);
      tbl[26] = mk(1,1,1,0, 0,3'b000,0, 0,0,0,0);
      tbl[27] = mk(1,1,1,0, 1,3'b001,2, 0,1,0,0);
      tbl[28] = mk(1,1,1,0, 1,3'b001,2, 0,1,0,0);
      tbl[29] = mk(1,1,0,0, 0,3'b001,2, 0,1,0,0);
      tbl[30] = mk(1,1,0,0, 0,3'b000,0, 0,0,0,0);
      tbl[31] = mk(1,1,0,0, 0,3'b000,0, 0,0,0,0);
      tbl[32] = mk(1,1,0,0, 1,3'b000,1, 1,0,0,0);
      tbl[33] = mk(1,1,0,1, 1,3'b000,1, 1,0,1,0);

      rst_i = 1'b1;
      set_in(0, 0, 0, 0);
      bus.wr_app_addr = '0;
      bus.rd_app_addr = '0;
      #2;
      check("reset_app_en", bus.app_en, 0);
      check("reset_grants", {bus.wr_grant, bus.rd_grant}, 2'b00);
      check("reset_rdys", {bus.wr_app_rdy, bus.rd_app_rdy}, 2'b00);
      check("reset_addr", bus.app_addr, 0);
      check("reset_cmd", bus.app_cmd, 0);
      next_cyc();
      rst_i = 1'b0;

      for (int i = 0; i < 34; i++) begin
         wa = 26'h0AB0000 + 26'(i);
         ra = 26'h1CD0000 + 26'(i);
         bus.wr_app_addr = wa;
         bus.rd_app_addr = ra;
         set_in(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].y);
         #3;
         ea = (tbl[i].src == 1) ? wa : (tbl[i].src == 2) ? ra : 26'h0;
         check($sformatf("vec%0d_app_en", i), bus.app_en, tbl[i].en);
         check($sformatf("vec%0d_cmd", i), bus.app_cmd, tbl[i].cmd);
         check($sformatf("vec%0d_addr", i), bus.app_addr, ea);
         check($sformatf("vec%0d_wr_grant", i), bus.wr_grant, tbl[i].wg);
         check($sformatf("vec%0d_rd_grant", i), bus.rd_grant, tbl[i].rg);
         check($sformatf("vec%0d_wr_rdy", i), bus.wr_app_rdy, tbl[i].wy);
         check($sformatf("vec%0d_rd_rdy", i), bus.rd_app_rdy, tbl[i].ry);
         next_cyc();
      end

      // Scoreboard: both sides always requesting, MIG always ready. Expect
      // alternating bursts of MAX_BURST with TURNAROUND idle cycles between,
      // write first after reset.
      do_reset();
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < MAX_BURST; k++) begin
            it.cmd  = b[0] ? 3'b001 : 3'b000;
            it.addr = (b[0] ? 26'h2200000 : 26'h0100000) + 26'((b / 2) * MAX_BURST + k);
            it.gap  = (k != 0) ? 0 : (b == 0) ? -1 : TURNAROUND;
            sbq.push_back(it);
         end
      end
      set_in(1, 1, 1, 1);
      wk = 0; rk = 0; idle = 0; cycles = 0;
      while (sbq.size() > 0 && cycles < 400) begin
         bus.wr_app_addr = 26'h0100000 + 26'(wk);
         bus.rd_app_addr = 26'h2200000 + 26'(rk);
         #3;
         wacc = bus.wr_app_en & bus.wr_app_rdy;
         racc = bus.rd_app_en & bus.rd_app_rdy;
         if (bus.app_en && bus.app_rdy) begin
            it = sbq.pop_front();
            check("sb_cmd", bus.app_cmd, it.cmd);
            check("sb_addr", bus.app_addr, it.addr);
            if (it.gap >= 0) check("sb_idle_gap", idle, it.gap);
            idle = 0;
         end else begin
            idle++;
         end
         next_cyc();
         if (wacc) wk++;
         if (racc) rk++;
         cycles++;
      end
      check("sb_drained", sbq.size(), 0);
      set_in(1, 0, 0, 0);

      stall_yield(1'b1, 20);
      stall_yield(1'b0, 100);

      // Asynchronous reset in the middle of a write burst
      do_reset();
      set_in(1, 1, 0, 1);
      bus.wr_app_addr = 26'h0055555;
      next_cyc();
      next_cyc();
      #3;
      check("pre_reset_app_en", bus.app_en, 1);
      #1;
      rst_i = 1'b1;
      #1;
      check("async_rst_app_en", bus.app_en, 0);
      check("async_rst_wr_grant", bus.wr_grant, 0);
      check("async_rst_wr_rdy", bus.wr_app_rdy, 0);
      next_cyc();
      rst_i = 1'b0;
      #3;
      check("post_rst_idle_grant", bus.wr_grant, 0);
      check("post_rst_idle_app_en", bus.app_en, 0);
      next_cyc();
      #3;
      check("post_rst_regrant", bus.wr_grant, 1);
      check("post_rst_app_en", bus.app_en, 1);
      next_cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
